// File: rtl/dif_butterfly_pkg.sv
// Shared pipeline depths and mode encoding for the INTT Gentleman-Sande butterfly.
// Depths match the DIT butterfly so both datapaths present identical latency.
package dif_butterfly_pkg;

  localparam int INTMUL_DELAY   = 3;
  localparam int MODRED_DELAY   = 2;
  localparam int MODMULT_DELAY  = INTMUL_DELAY + MODRED_DELAY + 1;
  localparam int DIF_BF_LATENCY = INTMUL_DELAY + MODRED_DELAY + 3;

  typedef enum logic {
    MODE_DIF = 1'b0,
    MODE_MUL = 1'b1
  } bf_mode_e;

endpackage

// File: rtl/dif_butterfly_mod_half.sv
// Combinational x * 2^-1 mod q for odd q; also used by the INTT output scaler.
module mod_half #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH:0] xPlusQ;

  // An odd x plus an odd q is even, so the shift is exact and stays below q.
  assign xPlusQ = {1'b0, x_i} + {1'b0, q_i};
  assign y_o    = x_i[0] ? WIDTH'(xPlusQ >> 1) : (x_i >> 1);

endmodule

// File: rtl/dif_butterfly.sv
// DIF butterfly: A_out = A+B, B_out = (A-B)*W mod q, optional halving, plus a plain
// modular-multiply mode. Fully pipelined, one operation per cycle, valid-tagged.
module dif_butterfly
  import dif_butterfly_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic             mode,
  input  logic             swap,
  input  logic             halve,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] modulus,
  output logic             valid_out,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out
);

  localparam int LAT = DIF_BF_LATENCY;

  logic [WIDTH-1:0] addRaw, subRaw, sumFull, diffFull, sumHalf, diffHalf;
  logic [WIDTH-1:0] sum_d, diff_d;
  logic             doHalve;

  logic [WIDTH-1:0] sum_q, diff_q, a_q, b_q, w_q, q_q;
  bf_mode_e         mode_q;
  logic             swap_q;
  logic [LAT-1:0]   validPipe_q;

  logic [WIDTH-1:0]   mulOp, passOp;
  logic [2*WIDTH-1:0] prod_q [INTMUL_DELAY];
  logic [WIDTH-1:0]   red_q  [MODRED_DELAY+1];
  logic [WIDTH-1:0]   pass_q [MODMULT_DELAY];

  // q < 2^(WIDTH-1) keeps A+B inside WIDTH bits, so no carry bit is needed.
  assign addRaw   = A + B;
  assign sumFull  = (addRaw >= modulus) ? (addRaw - modulus) : addRaw;
  assign subRaw   = A - B;
  assign diffFull = (A >= B) ? subRaw : (subRaw + modulus);

  mod_half #(.WIDTH(WIDTH)) u_halfSum (
    .x_i (sumFull),
    .q_i (modulus),
    .y_o (sumHalf)
  );

  mod_half #(.WIDTH(WIDTH)) u_halfDiff (
    .x_i (diffFull),
    .q_i (modulus),
    .y_o (diffHalf)
  );

  assign doHalve = halve && (bf_mode_e'(mode) == MODE_DIF);
  assign sum_d   = doHalve ? sumHalf  : sumFull;
  assign diff_d  = doHalve ? diffHalf : diffFull;

  always_ff @(posedge clk) begin
    sum_q  <= sum_d;
    diff_q <= diff_d;
    a_q    <= A;
    b_q    <= B;
    w_q    <= W;
    q_q    <= modulus;
  end

  assign mulOp  = (mode_q == MODE_MUL) ? (swap_q ? a_q : b_q) : diff_q;
  assign passOp = (mode_q == MODE_MUL) ? (swap_q ? b_q : a_q) : sum_q;

  // q_q is only valid for reduction because the modulus is held while the pipe is busy.
  always_ff @(posedge clk) begin
    prod_q[0] <= {{WIDTH{1'b0}}, mulOp} * {{WIDTH{1'b0}}, w_q};
    for (int i = 1; i < INTMUL_DELAY; i++) prod_q[i] <= prod_q[i-1];
    red_q[0] <= WIDTH'(prod_q[INTMUL_DELAY-1] % {{WIDTH{1'b0}}, q_q});
    for (int i = 1; i <= MODRED_DELAY; i++) red_q[i] <= red_q[i-1];
    pass_q[0] <= passOp;
    for (int i = 1; i < MODMULT_DELAY; i++) pass_q[i] <= pass_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validPipe_q <= '0;
      mode_q      <= MODE_DIF;
      swap_q      <= 1'b0;
      A_out       <= '0;
      B_out       <= '0;
    end else begin
      validPipe_q <= {validPipe_q[LAT-2:0], valid_in};
      mode_q      <= bf_mode_e'(mode);
      swap_q      <= swap;
      if (validPipe_q[LAT-2]) begin
        A_out <= pass_q[MODMULT_DELAY-1];
        B_out <= red_q[MODRED_DELAY];
      end
    end
  end

  assign valid_out = validPipe_q[LAT-1];

endmodule

// File: tb/tb_dif_butterfly.sv
// Self-checking bench for dif_butterfly: directed vectors, random bursts and a mid-flight
// reset, compared against a plain-arithmetic modular model with a due-cycle queue.
module tb_dif_butterfly;
  import dif_butterfly_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = DIF_BF_LATENCY;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid_in, mode, swap, halve;
  logic [WIDTH-1:0] A, B, W, modulus;
  logic             valid_out;
  logic [WIDTH-1:0] A_out, B_out;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  exp_t expQ[$];
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   validSeen = 0;

  always #5 clk = ~clk;

  dif_butterfly #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .mode      (mode),
    .swap      (swap),
    .halve     (halve),
    .A         (A),
    .B         (B),
    .W         (W),
    .modulus   (modulus),
    .valid_out (valid_out),
    .A_out     (A_out),
    .B_out     (B_out)
  );

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: textbook modular arithmetic; halving is multiplication by the inverse of 2.
  function automatic void refModel(input logic m, input logic s, input logic h,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] w, input logic [63:0] q,
                                   output logic [63:0] ea, output logic [63:0] eb);
    logic [63:0] x, y, inv2;
    if (!m) begin
      x = (a + b) % q;
      y = (a + q - b) % q;
      if (h) begin
        inv2 = (q + 1) / 2;
        x = (x * inv2) % q;
        y = (y * inv2) % q;
      end
      ea = x;
      eb = (y * w) % q;
    end else begin
      ea = s ? b : a;
      eb = ((s ? a : b) * w) % q;
    end
  endfunction

  // Drive one cycle, then compare whatever the DUT should present after that edge.
  task automatic applyStimulus(input logic v, input logic m, input logic s, input logic h,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    logic [63:0] ea, eb;
    logic        expValid;
    exp_t        e;
    valid_in = v;
    mode     = m;
    swap     = s;
    halve    = h;
    A        = a;
    B        = b;
    W        = w;
    if (v) begin
      refModel(m, s, h, 64'(a), 64'(b), 64'(w), 64'(modulus), ea, eb);
      e.due = cyc + LAT;
      e.a   = ea[31:0];
      e.b   = eb[31:0];
      expQ.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    expValid = (expQ.size() > 0) && (expQ[0].due == cyc);
    checkOutput("valid_out", 64'(valid_out), 64'(expValid));
    if (valid_out) validSeen++;
    if (expValid) begin
      e = expQ.pop_front();
      checkOutput("A_out", 64'(A_out), 64'(e.a));
      checkOutput("B_out", 64'(B_out), 64'(e.b));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_in = 1'b0;
    mode     = 1'b0;
    swap     = 1'b0;
    halve    = 1'b0;
    A        = '0;
    B        = '0;
    W        = '0;
    modulus  = 32'd7681;
    #2;
    checkOutput("reset_valid", 64'(valid_out), 64'd0);
    checkOutput("reset_A_out", 64'(A_out), 64'd0);
    checkOutput("reset_B_out", 64'(B_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed vectors and boundaries, issued back to back.
    applyStimulus(1, 0, 0, 0, 5, 3, 2);
    applyStimulus(1, 0, 0, 0, 7680, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 3, 2, 1);
    applyStimulus(1, 0, 0, 1, 7680, 0, 1);
    applyStimulus(1, 0, 0, 0, 1234, 1234, 77);
    applyStimulus(1, 0, 0, 0, 900, 17, 0);
    applyStimulus(1, 1, 0, 0, 10, 20, 3);
    applyStimulus(1, 1, 1, 0, 10, 20, 3);
    idle(LAT + 2);
    checkOutput("directed_drained", 64'(expQ.size()), 64'd0);

    // 64 back-to-back random ops with mixed controls.
    validSeen = 0;
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(7680, 0), $urandom_range(7680, 0), $urandom_range(7680, 0));
    idle(LAT + 2);
    checkOutput("burst_valid_count", 64'(validSeen), 64'd64);

    // Wide modulus exercises the full product width.
    modulus = 32'h7FFF_FFFF;
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(32'h7FFF_FFFE, 0), $urandom_range(32'h7FFF_FFFE, 0),
                    $urandom_range(32'h7FFF_FFFE, 0));
    idle(LAT + 2);
    checkOutput("wide_drained", 64'(expQ.size()), 64'd0);

    // Reset with three ops in flight: outputs clear at once and nothing emerges later.
    modulus = 32'd7681;
    applyStimulus(1, 0, 0, 0, 100, 50, 9);
    applyStimulus(1, 1, 1, 0, 11, 22, 5);
    applyStimulus(1, 0, 0, 1, 7, 4000, 3);
    idle(1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(valid_out), 64'd0);
    checkOutput("midreset_A_out", 64'(A_out), 64'd0);
    checkOutput("midreset_B_out", 64'(B_out), 64'd0);
    expQ.delete();
    #2;
    reset_n = 1'b1;
    idle(LAT + 2);
    applyStimulus(1, 0, 0, 0, 5, 3, 2);
    idle(LAT + 1);
    checkOutput("final_drained", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
